seg_scan_scheduler: RTL and testbench

//  Scan scheduler for the 8-digit seven-segment display. Holds a double-buffered

---
 rtl/seg_scan_scheduler.sv | 131 +++++++++++++
 tb/tb_seg_scan_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// Eight-digit seven-segment scan scheduler.
// A host fills a shadow frame (nibbles, digit mask, brightness). The frame is
// copied into the active frame only at a frame boundary, so the display never
// tears. The active frame is time-multiplexed onto active-low anodes.
//
// Handshake: commit is a one-cycle request with no ready. busy is high from the
// cycle after the request until commit_done, and further commits during that
// window merge into the same request. commit_done pulses for exactly one cycle
// on the cycle the new frame first appears (digit 0 slot).
module seg_scan_scheduler #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 480,
    parameter int BRIGHT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [3:0]          wr_data,
    input  logic [7:0]          shadow_mask,
    input  logic [BRIGHT_W-1:0] shadow_brt,
    input  logic                commit,
    input  logic                blank,
    output logic [7:0]          anode,
    output logic [2:0]          S,
    output logic [3:0]          hex,
    output logic                commit_done,
    output logic                busy,
    output logic                dbg_state
);

    localparam int DIV    = CLK_HZ / REFRESH_HZ;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    // (brt+1)*DIV never exceeds 2^(BRIGHT_W+PRE_W), so one spare bit is enough.
    localparam int PROD_W = PRE_W + BRIGHT_W + 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    typedef enum logic {ST_OFF = 1'b0, ST_ON = 1'b1} state_t;

    state_t              state;
    logic [PRE_W-1:0]    pre;
    logic [3:0]          shadow [8];
    logic [3:0]          active [8];
    logic [7:0]          mask;
    logic [BRIGHT_W-1:0] brt;
    logic                pending;

    logic                slot_end;
    logic                frame_end;
    logic                load;
    logic [PRE_W-1:0]    pre_n;
    logic [2:0]          s_n;
    logic [3:0]          shadow_n [8];
    logic [7:0]          mask_n;
    logic [3:0]          hex_n;
    state_t              state_n;
    logic [PROD_W-1:0]   on_prod;
    logic [PROD_W-1:0]   on_cyc;

    assign dbg_state = (state == ST_ON);

    // Lit time per slot from brightness, full width before the shift, clamped to 1.
    always_comb begin
        on_prod = (PROD_W'(brt) + PROD_W'(1)) * PROD_W'(DIV);
        on_cyc  = on_prod >> BRIGHT_W;
        if (on_cyc == '0) on_cyc = PROD_W'(1);
    end

    // Next-cycle slot position, frame load decision and FSM transition.
    always_comb begin
        slot_end  = (pre == PRE_MAX);
        frame_end = slot_end && (S == 3'd7);
        pre_n     = slot_end ? '0 : pre + PRE_W'(1);
        s_n       = slot_end ? S + 3'd1 : S;
        // A commit arriving on the boundary cycle itself is honoured there.
        load      = frame_end && (pending || commit);
        // Forward this cycle's write so it is part of a commit loaded on this edge.
        for (int i = 0; i < 8; i++) begin
            shadow_n[i] = (wr_en && wr_addr == 3'(i)) ? wr_data : shadow[i];
        end
        mask_n = load ? shadow_mask : mask;
        hex_n  = load ? shadow_n[s_n] : active[s_n];
        if (slot_end) begin
            state_n = mask_n[s_n] ? ST_ON : ST_OFF;
        end else if (state == ST_ON && PROD_W'(pre_n) < on_cyc) begin
            state_n = ST_ON;
        end else begin
            state_n = ST_OFF;
        end
    end

    // All state and registered outputs; blank is applied to the registered anode.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre         <= '0;
            S           <= 3'd0;
            state       <= ST_ON;
            anode       <= 8'hFF;
            hex         <= 4'd0;
            mask        <= 8'hFF;
            brt         <= '1;
            pending     <= 1'b0;
            busy        <= 1'b0;
            commit_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
        end else begin
            pre         <= pre_n;
            S           <= s_n;
            state       <= state_n;
            hex         <= hex_n;
            anode       <= (state_n == ST_ON && !blank) ? ~(8'd1 << s_n) : 8'hFF;
            pending     <= load ? 1'b0 : (pending || commit);
            busy        <= load ? 1'b0 : (pending || commit);
            commit_done <= load;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= shadow_n[i];
            end
            if (load) begin
                mask <= shadow_mask;
                brt  <= shadow_brt;
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow_n[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler with DIV=16 and BRIGHT_W=4 (on time = brt+1).
module tb_seg_scan_scheduler;

    localparam int DIV = 16;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] shadow_mask;
    logic [3:0] shadow_brt;
    logic       commit;
    logic       blank;
    logic [7:0] anode;
    logic [2:0] S;
    logic [3:0] hex;
    logic       commit_done;
    logic       busy;
    logic       dbg_state;

    seg_scan_scheduler #(.CLK_HZ(1600), .REFRESH_HZ(100), .BRIGHT_W(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .shadow_mask(shadow_mask), .shadow_brt(shadow_brt),
        .commit(commit), .blank(blank), .anode(anode), .S(S), .hex(hex),
        .commit_done(commit_done), .busy(busy), .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: cycle count since reset gives slot and position directly
    int         k;
    logic [3:0] m_sh [8];
    logic [3:0] m_act [8];
    logic [7:0] m_mask;
    logic [3:0] m_brt;
    bit         m_pend;
    logic [7:0] e_anode;
    logic [2:0] e_S;
    logic [3:0] e_hex;
    logic       e_done;
    logic       e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int pre, sl, on;
        bit pend;
        if (reset) begin
            k = 0;
            for (int i = 0; i < 8; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            m_mask = 8'hFF; m_brt = 4'hF; m_pend = 0;
            e_done = 0; e_busy = 0; e_S = 0; e_hex = 0; e_anode = 8'hFF;
            return;
        end
        pre = k % DIV;
        sl  = (k / DIV) % 8;
        if (wr_en) m_sh[wr_addr] = wr_data;
        pend   = m_pend || commit;
        e_done = 0;
        if (pre == DIV - 1 && sl == 7 && pend) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
            m_mask = shadow_mask;
            m_brt  = shadow_brt;
            e_done = 1;
            pend   = 0;
        end
        m_pend = pend;
        k++;
        pre = k % DIV;
        sl  = (k / DIV) % 8;
        on  = ((int'(m_brt) + 1) * DIV) >> 4;
        if (on < 1) on = 1;
        e_S    = 3'(sl);
        e_hex  = m_act[sl];
        e_busy = m_pend;
        e_anode = (!blank && m_mask[sl] && pre < on) ? (8'hFF ^ (8'h1 << sl)) : 8'hFF;
    endtask

    // one clock: model follows the edge, outputs compared 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("anode", 32'(anode), 32'(e_anode));
        chk("S", 32'(S), 32'(e_S));
        chk("hex", 32'(hex), 32'(e_hex));
        chk("commit_done", 32'(commit_done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!commit_done && n < budget) begin tick(); n++; end
        chk("done_seen", 32'(commit_done), 32'd1);
    endtask

    task automatic wait_s(input logic [2:0] t, input int budget);
        int n = 0;
        while (S != t && n < budget) begin tick(); n++; end
        chk("s_reached", 32'(S), 32'(t));
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         blk;
        int         cyc;
        logic [2:0] s;
        logic [7:0] an;
        logic [3:0] hx;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lit;
        int dones;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        shadow_mask = 8'hFF; shadow_brt = 4'hF; commit = 1'b0; blank = 1'b0;
        k = 0; m_pend = 0; m_mask = 8'hFF; m_brt = 4'hF;
        for (int i = 0; i < 8; i++) begin m_sh[i] = 0; m_act[i] = 0; end

        // reset values, first slots, blank response, S wrap
        tbl[0] = '{1, 0, 1,  3'd0, 8'hFF, 4'h0};
        tbl[1] = '{0, 0, 1,  3'd0, 8'hFE, 4'h0};
        tbl[2] = '{0, 0, 14, 3'd0, 8'hFE, 4'h0};
        tbl[3] = '{0, 0, 1,  3'd1, 8'hFD, 4'h0};
        tbl[4] = '{0, 1, 1,  3'd1, 8'hFF, 4'h0};
        tbl[5] = '{0, 0, 1,  3'd1, 8'hFD, 4'h0};
        tbl[6] = '{0, 0, 96, 3'd7, 8'h7F, 4'h0};
        tbl[7] = '{0, 0, 14, 3'd0, 8'hFE, 4'h0};
        for (int v = 0; v < 8; v++) begin
            reset = tbl[v].rst;
            blank = tbl[v].blk;
            for (int c = 0; c < tbl[v].cyc; c++) tick();
            reset = 1'b0;
            chk($sformatf("tbl%0d_S", v), 32'(S), 32'(tbl[v].s));
            chk($sformatf("tbl%0d_anode", v), 32'(anode), 32'(tbl[v].an));
            chk($sformatf("tbl%0d_hex", v), 32'(hex), 32'(tbl[v].hx));
        end
        blank = 1'b0;

        // digits 0..7 = 1..8, commit together with the last write
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
            commit = (i == 7);
            tick();
        end
        wr_en = 1'b0; commit = 1'b0;
        wait_done(300);
        for (int j = 0; j < 9; j++) begin
            chk("t1_S", 32'(S), 32'(j % 8));
            chk("t1_hex", 32'(hex), 32'((j % 8) + 1));
            chk("t1_anode", 32'(anode), 32'(8'hFF ^ (8'h1 << (j % 8))));
            repeat (16) tick();
        end

        // brightness 3: 4 lit cycles then 12 dark per slot
        shadow_brt = 4'd3;
        do_commit();
        wait_done(300);
        lit = 0;
        for (int c = 0; c < 16; c++) begin
            if (anode != 8'hFF) lit++;
            tick();
        end
        chk("t2_lit", 32'(lit), 32'd4);
        chk("t2_S_step", 32'(S), 32'd1);

        // mask AA: even digits dark, odd digits lit
        shadow_mask = 8'hAA;
        do_commit();
        wait_done(300);
        lit = 0;
        for (int c = 0; c < 16; c++) begin
            if (anode != 8'hFF) lit++;
            tick();
        end
        chk("t3_lit_d0", 32'(lit), 32'd0);
        lit = 0;
        for (int c = 0; c < 16; c++) begin
            if (anode != 8'hFF) lit++;
            tick();
        end
        chk("t3_lit_d1", 32'(lit), 32'd4);

        // mid-frame write of digit 5 plus commit
        wait_s(3'd3, 200);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hE; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("t4_busy", 32'(busy), 32'd1);
        wait_s(3'd5, 200);
        chk("t4_old_hex", 32'(hex), 32'd6);
        wait_done(200);
        chk("t4_done_S", 32'(S), 32'd0);
        wait_s(3'd5, 200);
        chk("t4_new_hex", 32'(hex), 32'hE);

        // reset with a commit pending discards it
        do_commit();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_anode", 32'(anode), 32'hFF);
        chk("t5_S", 32'(S), 32'd0);
        chk("t5_hex", 32'(hex), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        dones = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (commit_done) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            commit  = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            if ($urandom_range(0, 100) == 0) shadow_mask = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 100) == 0) shadow_brt = 4'($urandom_range(0, 15));
            reset   = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
